// File: rtl/spi_mem_master_pkg.sv
// Shared types for the jrb8 SPI memory master.
// Opcodes, frame geometry and FSM encoding.
package jrb8_spi_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_t;

  // Reads shift out a zero data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        wr,
    input logic [15:0] addr,
    input logic [7:0]  data
  );
    logic [7:0] op;
    logic [7:0] db;
    op = wr ? CMD_WRITE : CMD_READ;
    db = wr ? data : 8'h00;
    return {op, addr, db};
  endfunction

endpackage

// File: rtl/spi_mem_master_if.sv
// Request bus and SPI pins of the jrb8 memory master.
// master = the SPI block, slave = top level plus memory.
interface spi_mem_master_if;

  logic        start;
  logic        write;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;

  modport master (
    input  start,
    input  write,
    input  address,
    input  wdata,
    input  miso,
    output rdata,
    output busy,
    output done,
    output sclk,
    output cs,
    output mosi
  );

  modport slave (
    output start,
    output write,
    output address,
    output wdata,
    output miso,
    input  rdata,
    input  busy,
    input  done,
    input  sclk,
    input  cs,
    input  mosi
  );

endinterface

// File: rtl/spi_mem_master_sclk_div.sv
// SCLK half-period divider for the SPI memory master.
// Ticks every CLK_DIV cycles while enabled; sclk level picks the edge.
module spi_sclk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;
  logic         tick;

  assign tick      = en && (cnt == LAST);
  assign rise_tick = tick && !sclk;
  assign fall_tick = tick && sclk;

  // Held at zero while disabled so every frame starts phase-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// jrb8 SPI memory master: one 32-bit mode-0 frame per request.
// Opcode, 16-bit address and one data byte, all MSB first.
module spi_mem_master #(
  parameter int CLK_DIV = 1
) (
  input logic              clk,
  input logic              rst,
  spi_mem_master_if.master bus
);

  import jrb8_spi_pkg::*;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT =
    BIT_CNT_W'(FRAME_BITS - 1);

  spi_state_t state;
  spi_state_t state_n;

  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] tx_n;
  logic [7:0]            rx;
  logic [7:0]            rx_n;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt_n;
  logic [7:0]            rdata_q;
  logic [7:0]            rdata_n;
  logic                  wr_q;
  logic                  wr_n;
  logic                  sclk_q;
  logic                  sclk_n;
  logic                  mosi_q;
  logic                  mosi_n;
  logic                  cs_q;
  logic                  cs_n;
  logic                  busy_q;
  logic                  busy_n;
  logic                  done_q;
  logic                  done_n;

  logic div_en;
  logic rise_tick;
  logic fall_tick;

  assign div_en = (state == SHIFT);

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .sclk     (sclk_q),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      rx      <= rx_n;
      bit_cnt <= bit_cnt_n;
      rdata_q <= rdata_n;
      wr_q    <= wr_n;
      sclk_q  <= sclk_n;
      mosi_q  <= mosi_n;
      cs_q    <= cs_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    rx_n      = rx;
    bit_cnt_n = bit_cnt;
    rdata_n   = rdata_q;
    wr_n      = wr_q;
    sclk_n    = sclk_q;
    mosi_n    = mosi_q;

    unique case (state)
      IDLE: begin
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        if (bus.start) begin
          tx_n      = build_frame(bus.write, bus.address, bus.wdata);
          wr_n      = bus.write;
          rx_n      = '0;
          bit_cnt_n = '0;
          mosi_n    = tx_n[FRAME_BITS-1];
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        unique case (1'b1)
          rise_tick: begin
            sclk_n = 1'b1;
            rx_n   = {rx[6:0], bus.miso};
          end
          fall_tick: begin
            sclk_n    = 1'b0;
            tx_n      = tx << 1;
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              mosi_n  = 1'b0;
              state_n = DONE;
              // rx already holds the final bit sampled on the last rise.
              if (!wr_q) begin
                rdata_n = rx;
              end
            end else begin
              mosi_n = tx[FRAME_BITS-2];
            end
          end
          default: ;
        endcase
      end

      DONE: begin
        sclk_n  = 1'b0;
        mosi_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    cs_n   = (state_n != SHIFT);
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sclk  = sclk_q;
  assign bus.cs    = cs_q;
  assign bus.mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: CLK_DIV=1 and CLK_DIV=3 instances,
// SPI memory model per instance, scoreboard checked on done.
module tb_spi_mem_master;

  typedef struct {
    logic [31:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int k, input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %0h want %0h", k, n, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D = (g == 0) ? 1 : 3;

    spi_mem_master_if bus ();

    spi_mem_master #(
      .CLK_DIV(D)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
    );

    exp_t        exp_q[$];
    logic [7:0]  resp_next = 8'h00;
    logic [7:0]  resp_sh   = 8'h00;
    logic [31:0] cap       = 32'h0;
    int          rises     = 0;
    int          frames    = 0;
    int          cs_low    = 0;
    int          cs_high   = 0;
    int          run       = 0;
    int          e0        = 0;
    int          done_cyc  = 0;
    int          prev_done = 0;
    logic        busy_q    = 1'b0;
    logic        cs_q      = 1'b1;
    logic        sclk_q    = 1'b0;

    // Memory model: data byte returned during frame bits 24..31.
    assign bus.miso = (rises >= 24) ? resp_sh[7] : 1'b0;

    always @(posedge bus.sclk or negedge bus.cs) begin
      if (!bus.sclk) begin
        rises   = 0;
        cap     = 32'h0;
        resp_sh = resp_next;
      end else begin
        cap = {cap[30:0], bus.mosi};
        if (rises >= 24) resp_sh = {resp_sh[6:0], 1'b0};
        rises++;
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        busy_q = 1'b0;
        cs_q   = 1'b1;
        sclk_q = 1'b0;
        run    = 0;
      end else begin
        if (bus.busy && !busy_q) e0 = cyc;
        if (!bus.cs && cs_q) begin
          chk(g, "cs_gap", 32'(cs_high >= 1), 1);
          frames++;
          cs_low  = 0;
          cs_high = 0;
          run     = 0;
        end
        if (!bus.cs) cs_low++;
        else cs_high++;
        if (bus.sclk != sclk_q) begin
          if (!cs_q) chk(g, "sclk_half", run, D);
          run = 1;
        end else begin
          run++;
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk(g, "extra_done", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk(g, "rdata", 32'(bus.rdata), 32'(e.rdata));
            chk(g, "mosi_frame", cap, e.frame);
            chk(g, "done_lat", cyc - e0, 64 * D);
            chk(g, "cs_low", cs_low, 64 * D);
            chk(g, "done_cs", 32'(bus.cs), 1);
            chk(g, "done_busy", 32'(bus.busy), 1);
            prev_done = done_cyc;
            done_cyc  = cyc;
          end
        end
        busy_q = bus.busy;
        cs_q   = bus.cs;
        sclk_q = bus.sclk;
      end
    end
  end

  task automatic wait_idle0();
    int n = 0;
    @(negedge clk);
    while (u[0].bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (u[0].bus.busy) chk(0, "idle_timeout", 32'(u[0].bus.busy), 0);
  endtask

  task automatic issue0(input logic wr, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rb,
                        input logic [31:0] fr, input logic [7:0] rd);
    exp_t e;
    wait_idle0();
    e.frame = fr;
    e.rdata = rd;
    u[0].exp_q.push_back(e);
    u[0].resp_next   = rb;
    u[0].bus.write   = wr;
    u[0].bus.address = a;
    u[0].bus.wdata   = wd;
    u[0].bus.start   = 1'b1;
    @(posedge clk);
    #1;
    u[0].bus.start   = 1'b0;
    u[0].bus.write   = ~wr;
    u[0].bus.address = ~a;
    u[0].bus.wdata   = ~wd;
  endtask

  initial begin
    exp_t e;
    int   n;
    clk = 1'b0;
    rst = 1'b1;
    u[0].bus.start   = 1'b0;
    u[0].bus.write   = 1'b0;
    u[0].bus.address = 16'h0;
    u[0].bus.wdata   = 8'h0;
    u[1].bus.start   = 1'b0;
    u[1].bus.write   = 1'b0;
    u[1].bus.address = 16'h0;
    u[1].bus.wdata   = 8'h0;

    repeat (3) @(negedge clk);
    chk(0, "rst_cs", 32'(u[0].bus.cs), 1);
    chk(0, "rst_sclk", 32'(u[0].bus.sclk), 0);
    chk(0, "rst_mosi", 32'(u[0].bus.mosi), 0);
    chk(0, "rst_busy", 32'(u[0].bus.busy), 0);
    chk(0, "rst_done", 32'(u[0].bus.done), 0);
    chk(0, "rst_rdata", 32'(u[0].bus.rdata), 0);
    chk(1, "rst_cs", 32'(u[1].bus.cs), 1);
    rst = 1'b0;

    issue0(1'b0, 16'h1234, 8'h77, 8'hA5, 32'h0312_3400, 8'hA5);
    issue0(1'b0, 16'h0000, 8'h00, 8'h3C, 32'h0300_0000, 8'h3C);
    issue0(1'b1, 16'hBEEF, 8'h5A, 8'hC3, 32'h02BE_EF5A, 8'h3C);

    // Divider: CLK_DIV=3 instance
    @(negedge clk);
    e.frame = 32'h0300_FF00;
    e.rdata = 8'h96;
    u[1].exp_q.push_back(e);
    u[1].resp_next   = 8'h96;
    u[1].bus.address = 16'h00FF;
    u[1].bus.start   = 1'b1;
    @(posedge clk);
    #1;
    u[1].bus.start   = 1'b0;
    u[1].bus.address = 16'h1111;
    n = 0;
    while (u[1].exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(1, "div_drain", u[1].exp_q.size(), 0);

    // Start while busy, at bit 5
    issue0(1'b0, 16'h0F0F, 8'h00, 8'h5C, 32'h030F_0F00, 8'h5C);
    repeat (10) @(posedge clk);
    #1;
    u[0].bus.address = 16'hFFFF;
    u[0].bus.write   = 1'b1;
    u[0].bus.start   = 1'b1;
    @(posedge clk);
    #1;
    u[0].bus.start   = 1'b0;

    // Reset at bit 10
    issue0(1'b0, 16'h2222, 8'h00, 8'h77, 32'h0322_2200, 8'h77);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk(0, "mid_rst_cs", 32'(u[0].bus.cs), 1);
    chk(0, "mid_rst_sclk", 32'(u[0].bus.sclk), 0);
    chk(0, "mid_rst_busy", 32'(u[0].bus.busy), 0);
    chk(0, "mid_rst_done", 32'(u[0].bus.done), 0);
    chk(0, "mid_rst_mosi", 32'(u[0].bus.mosi), 0);
    chk(0, "mid_rst_rdata", 32'(u[0].bus.rdata), 0);
    u[0].exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue0(1'b0, 16'h1357, 8'h00, 8'hE1, 32'h0313_5700, 8'hE1);

    // Back-to-back with start held high
    wait_idle0();
    e.frame = 32'h03A0_A000;
    e.rdata = 8'h11;
    u[0].exp_q.push_back(e);
    e.rdata = 8'h22;
    u[0].exp_q.push_back(e);
    u[0].resp_next   = 8'h11;
    u[0].bus.write   = 1'b0;
    u[0].bus.address = 16'hA0A0;
    u[0].bus.start   = 1'b1;
    @(posedge clk);
    #1;
    u[0].resp_next = 8'h22;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u[0].bus.done && n < 200);
    chk(0, "b2b_done1", 32'(u[0].bus.done), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!u[0].bus.busy && n < 10);
    chk(0, "b2b_accept2", 32'(u[0].bus.busy), 1);
    u[0].bus.start = 1'b0;
    n = 0;
    while (u[0].exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(0, "b2b_drain", u[0].exp_q.size(), 0);
    chk(0, "b2b_period", u[0].done_cyc - u[0].prev_done, 66);

    repeat (10) @(negedge clk);
    chk(0, "frames", u[0].frames, 8);
    chk(1, "frames", u[1].frames, 1);
    chk(0, "idle_end", 32'(u[0].bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

SPI master that performs single-byte reads and writes to the external serial SRAM/flash on the `uio` pins (23LC512-style: 8-bit opcode, 16-bit address, 8-bit data, mode 0). It sits directly below the computer top level. The top presents a request: start, write, address (PC for ROM fetch or {mpage, mar} for RAM), and write data. This block returns the read byte with a one-cycle done pulse. Chip-select steering to the ROM or RAM device stays in the top level.

## Interface
Parameters:
- `CLK_DIV`, default 1: system clocks per SCLK half-period (≥1). SCLK frequency is clk/(2·CLK_DIV).

Ports:
- `clk` input 1: system clock. Everything is on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: level request, sampled only in IDLE.
- `write` input 1: 1 = WRITE (0x02), 0 = READ (0x03). Sampled with start.
- `address` input 16: byte address, MSB first on the wire. Sampled with start.
- `wdata` input 8: write data. Sampled with start.
- `rdata` output 8: last byte read. Held until the next read completes.
- `busy` output 1: high from the cycle after start is accepted through the done cycle.
- `done` output 1: one-cycle pulse at transaction end.
- `sclk` output 1: SPI clock, idles low.
- `cs` output 1: chip select, active-low, idles high.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

## Operation
- Frame is 32 bits: opcode[7:0], address[15:0], data[7:0], all MSB first.
  - For reads, the data byte shifted out on mosi is 0x00.
- States: IDLE → SHIFT → DONE → IDLE.
- IDLE:
  - cs=1, sclk=0, mosi=0, busy=0.
  - If start=1, load the 32-bit tx shift register from {opcode, address, wdata or 0}.
  - Clear the bit counter and the divider. Drive cs=0 and mosi=frame bit 31. Go to SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV−1. On its terminal count, sclk toggles.
  - Rising toggle (0→1): shift miso into the 8-bit rx register.
  - Falling toggle (1→0): shift tx left, mosi = next bit, bit counter +1.
  - On the 32nd falling toggle go to DONE, with sclk=0 and mosi=0.
- DONE:
  - cs=1, done=1, busy=1.
  - Reads: rdata ← rx. Writes: rdata unchanged.
  - Next state is IDLE.
- start while busy is ignored. There is no queueing.
- A start held high starts a new frame from IDLE. This gives at least one IDLE cycle (cs high) between frames.
- Inputs `address`/`write`/`wdata` may change freely after the accepting edge.
- Reset, at any time including mid-frame: state=IDLE, cs=1, sclk=0, mosi=0, done=0, busy=0, rdata=0x00, and shift registers and counters cleared. No partial frame resumes.

## Timing
- Accepting edge = E0. cs falls and mosi carries bit 31 after E0.
- First sclk rise occurs CLK_DIV cycles after E0. Each bit takes 2·CLK_DIV cycles.
- Last falling edge occurs at E0 + 64·CLK_DIV. `done`=1 and cs=1 during the following cycle. rdata is valid from the same edge that raises done.
- Earliest next accept is 2 cycles after the done edge (DONE cycle, then IDLE).
- Total start-to-start period is 64·CLK_DIV + 2 cycles.
- miso is sampled at the sclk rising edge. mosi changes only while sclk is low (mode 0).

## Structure
- Package `jrb8_spi_pkg` holds:
  - `CMD_READ`=8'h03 and `CMD_WRITE`=8'h02
  - `FRAME_BITS`=32
  - the state enum `spi_state_t` {IDLE, SHIFT, DONE}
- Sub-module `spi_sclk_div`: half-period divider with CLK_DIV parameter, enable, and outputs `rise_tick`/`fall_tick`. The master FSM consumes the ticks and owns the sclk register.

## Test plan
- **Read:** CLK_DIV=1, read 0x1234, MISO model returns 0xA5.
  - mosi = 03 12 34 00.
  - done at E0+65, rdata=0xA5.
  - cs low exactly 64 cycles.
- **Write:** write 0xBEEF with data 0x5A, after a prior read of 0x3C.
  - mosi = 02 BE EF 5A.
  - rdata stays 0x3C, done pulses once.
- **Divider timing:** CLK_DIV=3, read 0x00FF.
  - sclk half-period 3 cycles.
  - done at E0+193, data correct.
- **Start while busy:** pulse start again at bit 5 with address 0xFFFF.
  - Frame unchanged, single done pulse.
  - No second frame.
- **Reset mid-frame:** assert rst at bit 10.
  - cs=1, sclk=0, busy=0, rdata=0x00 immediately (async).
  - A read after release completes normally.
- **Back-to-back:** start held high for two reads.
  - cs high ≥1 cycle between frames.
  - Two done pulses 66 cycles apart (CLK_DIV=1).
